alu_divide_seq: RTL and testbench
=================================

Name: alu_divide_seq

Overview:
- Multi-cycle signed 32-bit divider for the ALU's divide operation (select code 4'h9).
- Takes the same a/b operands as the combinational ALU paths and returns quotient on lo and remainder on hi.
- Issued by the datapath control unit through a start/done handshake.
- One restoring-division step per clock, so the long division path stays out of the single-cycle ALU mux.

Parameters:
- WIDTH, 32, operand and result width in bits (a, b, hi, lo).

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- a  input  WIDTH  dividend, two's complement.
- b  input  WIDTH  divisor, two's complement.
- busy  output  1  high while a division is in progress (CALC or FIX).
- done  output  1  one-cycle pulse when hi/lo are valid.
- div_zero  output  1  set with done when b was zero; held until next accepted start.
- hi  output  WIDTH  remainder.
- lo  output  WIDTH  quotient.

Behaviour:
- Reset: clr=1 asynchronously forces state IDLE and sets busy, done, div_zero, hi, lo, and all internal registers to 0.
- Reset mid-operation abandons the division; no done pulse is produced.
- States are IDLE, CALC, FIX.
- IDLE:
  - On an edge with start=1 and b!=0, latch |a|, |b|, sign_q = a[31]^b[31] and sign_r = a[31].
  - On that edge: clear the partial remainder and counter, clear div_zero, enter CALC, and set busy=1.
  - On an edge with start=1 and b==0: stay in IDLE, and on that edge set lo=32'hFFFFFFFF, hi=a, div_zero=1, done=1.
- CALC, restoring step per edge:
  - r' = {r[30:0], q[31]}; q is shifted left.
  - If r' >= |b|, then r = r' - |b| and new q[0] = 1; otherwise r = r' and q[0] = 0.
  - The counter increments on each step; after the 32nd step, go to FIX.
  - Magnitudes use unsigned 32-bit arithmetic; the partial remainder is WIDTH+1 bits wide for the compare/subtract.
- FIX:
  - On one edge, lo = sign_q ? -q : q and hi = sign_r ? -r : r, both two's complement and truncated to 32 bits.
  - On the same edge, set done=1 and busy=0, and return to IDLE.
- Latency: done is high in the cycle following the 33rd rising edge after the edge that sampled start (32 CALC edges plus 1 FIX edge).
  - done lasts exactly one cycle.
- Division semantics:
  - Quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - a = 32'h80000000 with b = 32'hFFFFFFFF yields lo = 32'h80000000 and hi = 0, wrapping without an error flag.
- hi and lo hold their last values until the next result is written; they are unchanged while busy.
- start is ignored while busy=1; no queuing.
- start asserted in the same cycle done is high is accepted, because the FSM is already in IDLE.
- a and b must only be stable on the start edge; later changes have no effect.

Decomposition:
- Shared package (alu_pkg):
  - WIDTH=32.
  - ALU select-code constants, ALU_DIV=4'h9 and ALU_MUL=4'h8.
  - Divider state encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
- One combinational sub-module, alu_divide_step:
  - Inputs: partial remainder, quotient MSB, and divisor magnitude.
  - Outputs: next remainder and quotient bit.
  - Reusable for a later unrolled or radix-4 variant.
- The top module holds the FSM, counter, sign latches, and final negation.

Test Plan:
- a=100, b=7, start for 1 cycle -> busy=1 for 33 cycles; then done=1 for 1 cycle with lo=32'h0000000E, hi=32'h00000002, div_zero=0.
- a=-100 (32'hFFFFFF9C), b=7 -> lo=32'hFFFFFFF2 (-14), hi=32'hFFFFFFFE (-2).
- a=100, b=-7 -> lo=32'hFFFFFFF2, hi=32'h00000002; a=-100, b=-7 -> lo=32'h0000000E, hi=32'hFFFFFFFE.
- a=7, b=0 -> one edge later: done=1, div_zero=1, lo=32'hFFFFFFFF, hi=32'h00000007, busy never asserted.
- a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0. Also a=0, b=5 -> lo=0, hi=0.
- Start a=100, b=7, re-pulse start with a=1, b=1 at cycle 5 -> second start ignored and result still 14/2.
- Start a=100, b=7, assert clr at cycle 10 -> all outputs 0 immediately and no done pulse; after release, start a=9, b=2 -> lo=4, hi=1.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath and its sequential divider:
//   - WIDTH          : operand/result width
//   - ALU_MUL/ALU_DIV: ALU select codes that route to the multi-cycle units
//   - div_state_e    : divider FSM state encoding
//   - magnitude()    : two's-complement absolute value (INT_MIN maps to
//                      2**(WIDTH-1), which is the correct unsigned magnitude)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] ALU_MUL = 4'h8;
  localparam logic [3:0] ALU_DIV = 4'h9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/alu_divide_seq_if.sv
// ---------------------------------------------------------------------------
// alu_divide_seq_if
// Start/done handshake between the datapath control unit and the divider.
//   start    : request a division (control -> divider)
//   a, b     : dividend / divisor, two's complement (control -> divider)
//   busy     : division in progress (divider -> control)
//   done     : one-cycle result-valid pulse (divider -> control)
//   div_zero : divisor was zero, held until the next accepted start
//   hi, lo   : remainder / quotient
// master = issuing side, slave = divider.
// ---------------------------------------------------------------------------
interface alu_divide_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/alu_divide_step.sv
// ---------------------------------------------------------------------------
// alu_divide_step
// One combinational restoring-division step on unsigned magnitudes.
//   rem_i   : current partial remainder (always < div_i)
//   q_msb_i : next dividend bit shifted into the remainder
//   div_i   : divisor magnitude
//   rem_o   : partial remainder after the step
//   q_bit_o : quotient bit produced by this step
// Kept standalone so an unrolled or higher-radix divider can chain copies.
// ---------------------------------------------------------------------------
module alu_divide_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  always_comb begin
    // The shifted remainder needs one extra bit before the compare, since
    // 2*rem + 1 can exceed WIDTH bits when the divisor is large.
    shifted = {rem_i, q_msb_i};
    q_bit_o = (shifted >= {1'b0, div_i});
    // When the subtraction is taken the result is < div_i, so the low WIDTH
    // bits of a modulo-2**WIDTH subtract are exact.
    trial   = shifted[WIDTH-1:0] - div_i;
    rem_o   = q_bit_o ? trial : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_divide_seq.sv
// ---------------------------------------------------------------------------
// alu_divide_seq
// Multi-cycle signed divider for the ALU divide operation. One restoring
// step per clock on magnitudes, then a single fix-up cycle applies signs:
// quotient truncates toward zero, remainder takes the dividend's sign.
//   clk : system clock, rising edge
//   clr : asynchronous active-high reset; abandons any division in flight
//   bus : alu_divide_seq_if.slave (start, a, b, busy, done, div_zero, hi, lo)
// Divide by zero finishes in one edge with lo = all ones, hi = a, div_zero.
// ---------------------------------------------------------------------------
module alu_divide_seq
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  alu_divide_seq_if.slave       bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] rem_q,     rem_d;      // partial remainder
  logic [WIDTH-1:0] quo_q,     quo_d;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvsr_q,    dvsr_d;     // divisor magnitude
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             dz_q,      dz_d;
  logic [WIDTH-1:0] hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  alu_divide_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q),
    .q_msb_i (quo_q[WIDTH-1]),
    .div_i   (dvsr_q),
    .rem_o   (step_rem),
    .q_bit_o (step_qbit)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.b == '0) begin
            lo_d   = '1;
            hi_d   = bus.a;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            quo_d     = magnitude(bus.a);
            dvsr_d    = magnitude(bus.b);
            sgn_quo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            sgn_rem_d = bus.a[WIDTH-1];
            rem_d     = '0;
            cnt_d     = '0;
            dz_d      = 1'b0;
            busy_d    = 1'b1;
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end

      FIX: begin
        lo_d    = sgn_quo_q ? -quo_q : quo_q;
        hi_d    = sgn_rem_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_alu_divide_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_divide_seq
// Self-checking bench for alu_divide_seq: a vector table of signed divisions
// plus directed sequences for busy-start, back-to-back start and mid-run reset.
// Expected results are queued when a start is driven and popped by a monitor
// whenever done is seen.
// ---------------------------------------------------------------------------
module tb_alu_divide_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  localparam int NV = 14;

  logic clk = 1'b0;
  logic clr;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[NV];

  alu_divide_seq_if #(.WIDTH(32)) ifc ();

  alu_divide_seq dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clr === 1'b0 && ifc.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'b0, ifc.done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("lo", ifc.lo, mon_e.lo);
        check("hi", ifc.hi, mon_e.hi);
        check("div_zero", {31'b0, ifc.div_zero}, {31'b0, mon_e.dz});
        $display("result lo=%h hi=%h dz=%0b", ifc.lo, ifc.hi, ifc.div_zero);
      end
    end
  end

  // Drive a one-cycle start; a/b are scrambled afterwards to show they are
  // only sampled on the start edge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] lo_e, input logic [31:0] hi_e, input logic dz_e);
    exp_t e;
    @(negedge clk);
    ifc.a     = av;
    ifc.b     = bv;
    ifc.start = 1'b1;
    e.lo = lo_e;
    e.hi = hi_e;
    e.dz = dz_e;
    sb.push_back(e);
    $display("issue a=%h b=%h expect lo=%h hi=%h dz=%0b", av, bv, lo_e, hi_e, dz_e);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.a     = $urandom;
    ifc.b     = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    exp_t e;

    vecs[0]  = '{32'd100,        32'd7,          32'h0000000E, 32'h00000002, 1'b0};
    vecs[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2, 32'h00000002, 1'b0};
    vecs[3]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{32'd7,          32'd0,          32'hFFFFFFFF, 32'h00000007, 1'b1};
    vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 1'b0};
    vecs[6]  = '{32'd0,          32'd5,          32'h00000000, 32'h00000000, 1'b0};
    vecs[7]  = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF, 32'h00000000, 1'b0};
    vecs[8]  = '{32'h80000000,   32'd1,          32'h80000000, 32'h00000000, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF,   32'd2,          32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{32'd5,          32'h80000000,   32'h00000000, 32'h00000005, 1'b0};
    vecs[11] = '{32'h80000000,   32'h80000000,   32'h00000001, 32'h00000000, 1'b0};
    vecs[12] = '{32'd1000000,    32'hFFFFFFFD,   32'hFFFAE9EB, 32'h00000001, 1'b0};
    vecs[13] = '{32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};

    clr       = 1'b1;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, ifc.busy}, 32'd0);
    check("rst_done", {31'b0, ifc.done}, 32'd0);
    check("rst_dz",   {31'b0, ifc.div_zero}, 32'd0);
    check("rst_hi",   ifc.hi, 32'd0);
    check("rst_lo",   ifc.lo, 32'd0);
    clr = 1'b0;

    // Table: result, busy length (33 or 0) and done right after busy drops.
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].dz);
      n = 0;
      while (ifc.busy === 1'b1 && n < 64) begin
        @(negedge clk);
        n++;
      end
      check("busy_cycles", n, vecs[i].dz ? 32'd0 : 32'd33);
      check("done_on_time", {31'b0, ifc.done}, 32'd1);
      wait_done(8);
    end

    // Start while busy is ignored.
    issue(32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0);
    repeat (3) @(negedge clk);
    ifc.a     = 32'd1;
    ifc.b     = 32'd1;
    ifc.start = 1'b1;
    $display("re-pulse start a=1 b=1 while busy");
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(60);
    repeat (40) @(negedge clk);

    // Start in the same cycle as done is accepted.
    issue(32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0);
    n = 0;
    while (ifc.done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", {31'b0, ifc.done}, 32'd1);
    ifc.a     = 32'd9;
    ifc.b     = 32'd2;
    ifc.start = 1'b1;
    e.lo = 32'd4;
    e.hi = 32'd1;
    e.dz = 1'b0;
    sb.push_back(e);
    $display("issue a=9 b=2 in done cycle expect lo=4 hi=1");
    @(negedge clk);
    ifc.start = 1'b0;
    check("b2b_busy", {31'b0, ifc.busy}, 32'd1);
    wait_done(60);

    // Reset mid-division: outputs clear at once, no done follows.
    issue(32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0);
    repeat (8) @(negedge clk);
    clr = 1'b1;
    sb.delete();
    #1;
    $display("clr asserted mid-division");
    check("clr_busy", {31'b0, ifc.busy}, 32'd0);
    check("clr_done", {31'b0, ifc.done}, 32'd0);
    check("clr_dz",   {31'b0, ifc.div_zero}, 32'd0);
    check("clr_hi",   ifc.hi, 32'd0);
    check("clr_lo",   ifc.lo, 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd9, 32'd2, 32'd4, 32'd1, 1'b0);
    wait_done(60);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
